// File: rtl/keypad_matrix_scan.sv
// Column-multiplexed keypad scanner: drives one column low at a time, reads pulled-up rows,
// classifies each full scan as none/one/multi and debounces across whole scans.
module keypad_matrix_scan #(
    parameter int COLS         = 4,
    parameter int ROWS         = 4,
    parameter int SETTLE       = 1024,
    parameter int STABLE_SCANS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ROWS-1:0]                row_in,
    output logic [COLS-1:0]                col_drv,
    output logic [$clog2(ROWS*COLS)-1:0]   key_code,
    output logic                           key_valid,
    output logic                           key_press,
    output logic                           key_release
);

    localparam int CW  = $clog2(ROWS*COLS);
    localparam int CLW = $clog2(COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int DW  = $clog2(SETTLE);
    localparam int SW  = $clog2(STABLE_SCANS+1);

    typedef enum logic [1:0] {RES_NONE = 2'd0, RES_ONE = 2'd1, RES_MULTI = 2'd2} result_t;
    typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

    logic [ROWS-1:0] row_meta_r;
    logic [ROWS-1:0] row_sync_r;
    logic [DW-1:0]   dwell_r;
    logic [CLW-1:0]  col_r;
    logic [CLW-1:0]  col_nxt_s;
    logic            sample_s;
    logic            scan_end_s;

    logic [1:0]      hit_cnt_r;
    logic [CW-1:0]   hit_code_r;
    logic [1:0]      col_cnt_s;
    logic [RW-1:0]   first_row_s;
    logic [2:0]      sum_s;
    logic [1:0]      total_s;
    logic [CW-1:0]   scan_code_s;
    result_t         scan_kind_s;

    result_t         prev_kind_r;
    logic [CW-1:0]   prev_code_r;
    logic [SW-1:0]   stable_cnt_r;
    logic [SW-1:0]   stable_nxt_s;
    logic            stable_full_s;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   code_nxt_s;
    logic            valid_nxt_s;
    logic            press_nxt_s;
    logic            release_nxt_s;

    assign sample_s   = (dwell_r == DW'(SETTLE-1));
    assign scan_end_s = sample_s && (col_r == CLW'(COLS-1));
    assign col_nxt_s  = (col_r == CLW'(COLS-1)) ? CLW'(0) : col_r + CLW'(1);

    // Two-flop synchronizer; idle rows read as released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_r <= {ROWS{1'b1}};
            row_sync_r <= {ROWS{1'b1}};
        end else begin
            row_meta_r <= row_in;
            row_sync_r <= row_meta_r;
        end
    end

    // Dwell counter and column drive sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_r <= DW'(0);
            col_r   <= CLW'(0);
            col_drv <= ~(COLS'(1));
        end else if (sample_s) begin
            dwell_r <= DW'(0);
            col_r   <= col_nxt_s;
            col_drv <= ~(COLS'(1) << col_nxt_s);
        end else begin
            dwell_r <= dwell_r + DW'(1);
        end
    end

    // Classify the sampled column and fold it into this scan's running result.
    always_comb begin
        col_cnt_s   = 2'd0;
        first_row_s = RW'(0);
        for (int r = ROWS-1; r >= 0; r--) begin
            first_row_s = row_sync_r[r] ? first_row_s : RW'(r);
            if (!row_sync_r[r] && (col_cnt_s != 2'd2)) begin
                col_cnt_s = col_cnt_s + 2'd1;
            end else begin
                col_cnt_s = col_cnt_s;
            end
        end
        sum_s       = {1'b0, hit_cnt_r} + {1'b0, col_cnt_s};
        total_s     = (sum_s > 3'd2) ? 2'd2 : sum_s[1:0];
        // Earlier columns win; within this column the lowest row wins.
        scan_code_s = (hit_cnt_r == 2'd0) ? (CW'(first_row_s) * CW'(COLS) + CW'(col_r)) : hit_code_r;
        case (total_s)
            2'd0:    scan_kind_s = RES_NONE;
            2'd1:    scan_kind_s = RES_ONE;
            default: scan_kind_s = RES_MULTI;
        endcase
    end

    // Per-scan hit accumulator, cleared at each scan end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_r  <= 2'd0;
            hit_code_r <= CW'(0);
        end else if (scan_end_s) begin
            hit_cnt_r  <= 2'd0;
            hit_code_r <= CW'(0);
        end else if (sample_s) begin
            hit_cnt_r  <= total_s;
            hit_code_r <= scan_code_s;
        end
    end

    // Stability count and FSM next state, only acted on at scan end.
    always_comb begin
        stable_nxt_s  = SW'(1);
        state_nxt_s   = state_r;
        code_nxt_s    = key_code;
        valid_nxt_s   = key_valid;
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
        if (scan_kind_s == RES_MULTI) begin
            stable_nxt_s = SW'(0);
        end else if ((scan_kind_s == prev_kind_r) &&
                     ((scan_kind_s == RES_NONE) || (scan_code_s == prev_code_r))) begin
            stable_nxt_s = (stable_cnt_r == SW'(STABLE_SCANS)) ? stable_cnt_r : stable_cnt_r + SW'(1);
        end else begin
            stable_nxt_s = SW'(1);
        end
        stable_full_s = (stable_nxt_s == SW'(STABLE_SCANS));
        if (scan_end_s) begin
            case (state_r)
                IDLE: begin
                    if ((scan_kind_s == RES_ONE) && stable_full_s) begin
                        state_nxt_s = HELD;
                        code_nxt_s  = scan_code_s;
                        valid_nxt_s = 1'b1;
                        press_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                HELD: begin
                    // A different single key while held is ignored until release.
                    if ((scan_kind_s == RES_NONE) && stable_full_s) begin
                        state_nxt_s   = IDLE;
                        valid_nxt_s   = 1'b0;
                        release_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = HELD;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    valid_nxt_s = 1'b0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Previous scan result and stability counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_kind_r  <= RES_NONE;
            prev_code_r  <= CW'(0);
            stable_cnt_r <= SW'(0);
        end else if (scan_end_s) begin
            prev_kind_r  <= scan_kind_s;
            prev_code_r  <= scan_code_s;
            stable_cnt_r <= stable_nxt_s;
        end
    end

    // FSM state and registered key outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            key_code    <= CW'(0);
            key_valid   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            key_code    <= code_nxt_s;
            key_valid   <= valid_nxt_s;
            key_press   <= press_nxt_s;
            key_release <= release_nxt_s;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Scoreboard bench for keypad_matrix_scan: stimulus pushes expected press/release events,
// a negedge monitor pops and compares them whenever the DUT pulses.
module tb_keypad_matrix_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_drv;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_press;
    logic       key_release;
    logic [15:0] pressed = 16'h0000;
    logic [4:0]  exp_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    keypad_matrix_scan #(.COLS(4), .ROWS(4), .SETTLE(4), .STABLE_SCANS(3)) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_drv(col_drv),
        .key_code(key_code), .key_valid(key_valid),
        .key_press(key_press), .key_release(key_release)
    );

    // Switch matrix model: a closed key pulls its row low while its column is driven.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_drv[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest expected event.
    always @(negedge clk) begin
        logic [4:0] e;
        if (!rst && (key_press || key_release)) begin
            check("no_coincide", 32'(key_press & key_release), 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse actual press=%0d release=%0d code=%0d required none",
                         key_press, key_release, key_code);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", 32'(key_press), 32'(e[4]));
                check("pulse_code", 32'(key_code), 32'(e[3:0]));
                check("pulse_valid", 32'(key_valid), 32'(e[4]));
            end
        end
    end

    task automatic sync_scan();
        int n = 0;
        while (col_drv != 4'b0111 && n < 40) begin @(negedge clk); n++; end
        while (col_drv != 4'b1110 && n < 80) begin @(negedge clk); n++; end
        total++;
        if (n >= 80) begin
            bad++;
            $display("FAIL scan_timeout actual=%0d required<80", n);
        end
    endtask

    task automatic wait_scans(input int n);
        for (int i = 0; i < n; i++) sync_scan();
    endtask

    initial begin
        logic [3:0] exp_col;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_col_drv", 32'(col_drv), 32'hE);
        check("rst_key_code", 32'(key_code), 32'd0);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_key_press", 32'(key_press), 32'd0);
        check("rst_key_release", 32'(key_release), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            check("col_drv_seq", 32'(col_drv), 32'(exp_col));
        end
        check("idle_valid", 32'(key_valid), 32'd0);

        // Key 9: row 2 / column 1.
        pressed[9] = 1'b1;
        exp_q.push_back({1'b1, 4'd9});
        wait_scans(2);
        check("k9_valid_before", 32'(key_valid), 32'd0);
        sync_scan();
        check("k9_valid", 32'(key_valid), 32'd1);
        check("k9_code", 32'(key_code), 32'd9);
        sync_scan();

        pressed[9] = 1'b0;
        exp_q.push_back({1'b0, 4'd9});
        wait_scans(2);
        check("k9_rel_before", 32'(key_valid), 32'd1);
        sync_scan();
        check("k9_rel_valid", 32'(key_valid), 32'd0);
        check("k9_rel_code", 32'(key_code), 32'd9);
        sync_scan();

        // Bouncing key 5 only accepted after three consecutive closed scans.
        exp_q.push_back({1'b1, 4'd5});
        for (int i = 0; i < 6; i++) begin
            pressed[5] = (i % 2 == 0);
            sync_scan();
        end
        check("bounce_valid", 32'(key_valid), 32'd0);
        pressed[5] = 1'b1;
        wait_scans(2);
        check("k5_valid_before", 32'(key_valid), 32'd0);
        sync_scan();
        check("k5_valid", 32'(key_valid), 32'd1);
        check("k5_code", 32'(key_code), 32'd5);
        pressed[5] = 1'b0;
        exp_q.push_back({1'b0, 4'd5});
        wait_scans(4);
        check("k5_rel_valid", 32'(key_valid), 32'd0);

        // Two keys together never count; dropping one leaves key 0.
        pressed[0]  = 1'b1;
        pressed[15] = 1'b1;
        wait_scans(5);
        check("multi_valid", 32'(key_valid), 32'd0);
        pressed[15] = 1'b0;
        exp_q.push_back({1'b1, 4'd0});
        wait_scans(2);
        check("k0_valid_before", 32'(key_valid), 32'd0);
        sync_scan();
        check("k0_valid", 32'(key_valid), 32'd1);
        check("k0_code", 32'(key_code), 32'd0);
        pressed[0] = 1'b0;
        exp_q.push_back({1'b0, 4'd0});
        wait_scans(4);
        check("k0_rel_valid", 32'(key_valid), 32'd0);

        // Reset while held, mid-dwell; the key must re-press afterwards.
        pressed[6] = 1'b1;
        exp_q.push_back({1'b1, 4'd6});
        wait_scans(4);
        check("k6_valid", 32'(key_valid), 32'd1);
        check("k6_code", 32'(key_code), 32'd6);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_col_drv", 32'(col_drv), 32'hE);
        check("mid_rst_valid", 32'(key_valid), 32'd0);
        check("mid_rst_code", 32'(key_code), 32'd0);
        check("mid_rst_press", 32'(key_press), 32'd0);
        check("mid_rst_release", 32'(key_release), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back({1'b1, 4'd6});
        wait_scans(2);
        check("k6_re_before", 32'(key_valid), 32'd0);
        sync_scan();
        check("k6_re_valid", 32'(key_valid), 32'd1);
        check("k6_re_code", 32'(key_code), 32'd6);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
